// File: rtl/palette_fader_if.sv
// Pixel lookup, palette write and fade-control signals between the index
// generators and the palette/fader block.
interface palette_fader_if #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned COMP_W  = 4,
  parameter int unsigned LEVEL_W = 4
);
  logic [INDEX_W-1:0]  index;
  logic                pix_valid;
  logic [COMP_W-1:0]   red;
  logic [COMP_W-1:0]   green;
  logic [COMP_W-1:0]   blue;
  logic                rgb_valid;
  logic                wr_en;
  logic [INDEX_W-1:0]  wr_addr;
  logic [3*COMP_W-1:0] wr_data;
  logic                frame_tick;
  logic                fade_start;
  logic                fade_dir;
  logic                fade_busy;
  logic                fade_done;
  logic [LEVEL_W:0]    level;

  modport master (
    output index, pix_valid, wr_en, wr_addr, wr_data, frame_tick, fade_start, fade_dir,
    input  red, green, blue, rgb_valid, fade_busy, fade_done, level
  );

  modport slave (
    input  index, pix_valid, wr_en, wr_addr, wr_data, frame_tick, fade_start, fade_dir,
    output red, green, blue, rgb_valid, fade_busy, fade_done, level
  );
endinterface

// File: rtl/palette_fader.sv
// Writable colour palette with a two-stage lookup pipeline and a per-frame
// brightness fade engine scaling every output component.
module palette_fader #(
  parameter int unsigned INDEX_W         = 4,
  parameter int unsigned COMP_W          = 4,
  parameter int unsigned LEVEL_W         = 4,
  parameter int unsigned FRAMES_PER_STEP = 1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  palette_fader_if.slave  bus
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned LVL_W   = LEVEL_W + 1;
  localparam int unsigned PROD_W  = COMP_W + LEVEL_W + 1;
  localparam int unsigned FC_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [LEVEL_W:0] LVL_MAX = LVL_W'(1 << LEVEL_W);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_FADE_IN  = 2'd2;

  typedef struct packed {
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
  } rgb_t;

  // Reset contents: linear grey ramp from black at entry 0 to white at the top.
  function automatic rgb_t grey(input int unsigned i);
    int unsigned cmax;
    int unsigned c;
    rgb_t        e;
    cmax = (32'd1 << COMP_W) - 32'd1;
    c    = (i * cmax) / ((32'd1 << INDEX_W) - 32'd1);
    e.r  = COMP_W'(c);
    e.g  = COMP_W'(c);
    e.b  = COMP_W'(c);
    return e;
  endfunction

  function automatic logic [COMP_W-1:0] scale(input logic [COMP_W-1:0] c,
                                              input logic [LEVEL_W:0]  l);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(l);
    return COMP_W'(p >> LEVEL_W);
  endfunction

  rgb_t             pal_q [ENTRIES];
  rgb_t             pal_d [ENTRIES];
  rgb_t             s1_q, s1_d, out_q, out_d;
  logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [1:0]       state_q, state_d;
  logic [LEVEL_W:0] level_q, level_d;
  logic [LEVEL_W:0] target;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Palette storage and lookup pipeline; stage 1 reads the pre-write contents.
  always_comb begin
    pal_d = pal_q;
    if (bus.wr_en) pal_d[bus.wr_addr] = rgb_t'(bus.wr_data);
    s1_d        = pal_q[bus.index];
    s1_valid_d  = bus.pix_valid;
    out_d.r     = scale(s1_q.r, level_q);
    out_d.g     = scale(s1_q.g, level_q);
    out_d.b     = scale(s1_q.b, level_q);
    out_valid_d = s1_valid_q;
  end

  // Fade engine: completion is decided on the stepping edge so busy/done
  // change together in the following cycle.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fc_d    = fc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    target  = (state_q == ST_FADE_IN) ? LVL_MAX : '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.fade_start) begin
          state_d = bus.fade_dir ? ST_FADE_IN : ST_FADE_OUT;
          fc_d    = '0;
          busy_d  = 1'b1;
        end
      end
      ST_FADE_OUT, ST_FADE_IN: begin
        if (level_q == target) begin
          state_d = ST_IDLE;
          fc_d    = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (bus.frame_tick) begin
          if (fc_q == FC_LAST) begin
            fc_d    = '0;
            level_d = (state_q == ST_FADE_OUT) ? level_q - LVL_W'(1) : level_q + LVL_W'(1);
            if (level_d == target) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) pal_q[i] <= grey(i);
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
      level_q     <= LVL_MAX;
      fc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pal_q       <= pal_d;
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      level_q     <= level_d;
      fc_q        <= fc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.red       = out_q.r;
  assign bus.green     = out_q.g;
  assign bus.blue      = out_q.b;
  assign bus.rgb_valid = out_valid_q;
  assign bus.fade_busy = busy_q;
  assign bus.fade_done = done_q;
  assign bus.level     = level_q;

endmodule

// File: tb/tb_palette_fader.sv
// Directed bench for palette_fader: lookup table vectors, read-first write,
// fades with one and three frames per step, reset abort and edge cases.
module tb_palette_fader;

  logic Clk;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;

  palette_fader_if #(.INDEX_W(4), .COMP_W(4), .LEVEL_W(4)) bus1 ();
  palette_fader_if #(.INDEX_W(4), .COMP_W(4), .LEVEL_W(4)) bus3 ();

  palette_fader #(.INDEX_W(4), .COMP_W(4), .LEVEL_W(4), .FRAMES_PER_STEP(1)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus1));
  palette_fader #(.INDEX_W(4), .COMP_W(4), .LEVEL_W(4), .FRAMES_PER_STEP(3)) u3 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus3));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [3:0]  idx;
    logic        v;
    logic [11:0] exp_rgb;
    logic        exp_v;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  function automatic int rgb1();
    return int'({bus1.red, bus1.green, bus1.blue});
  endfunction

  task automatic do_reset();
    Reset_n = 1'b0;
    cyc();
    cyc();
    Reset_n = 1'b1;
  endtask

  task automatic pulse_tick1();
    bus1.frame_tick = 1'b1;
    cyc();
    bus1.frame_tick = 1'b0;
  endtask

  task automatic pulse_tick3();
    bus3.frame_tick = 1'b1;
    cyc();
    bus3.frame_tick = 1'b0;
  endtask

  initial begin
    Reset_n         = 1'b0;
    bus1.index      = '0; bus1.pix_valid = 1'b0; bus1.wr_en = 1'b0;
    bus1.wr_addr    = '0; bus1.wr_data   = '0;   bus1.frame_tick = 1'b0;
    bus1.fade_start = 1'b0; bus1.fade_dir = 1'b0;
    bus3.index      = '0; bus3.pix_valid = 1'b0; bus3.wr_en = 1'b0;
    bus3.wr_addr    = '0; bus3.wr_data   = '0;   bus3.frame_tick = 1'b0;
    bus3.fade_start = 1'b0; bus3.fade_dir = 1'b0;

    vecs[0] = '{idx: 4'd15, v: 1'b1, exp_rgb: 12'hFFF, exp_v: 1'b1};
    vecs[1] = '{idx: 4'd5,  v: 1'b1, exp_rgb: 12'h555, exp_v: 1'b1};
    vecs[2] = '{idx: 4'd0,  v: 1'b1, exp_rgb: 12'h000, exp_v: 1'b1};
    vecs[3] = '{idx: 4'd9,  v: 1'b0, exp_rgb: 12'h999, exp_v: 1'b0};
    vecs[4] = '{idx: 4'd1,  v: 1'b1, exp_rgb: 12'h111, exp_v: 1'b1};
    vecs[5] = '{idx: 4'd12, v: 1'b1, exp_rgb: 12'hCCC, exp_v: 1'b1};

    cyc();
    do_reset();
    check("reset_rgb", rgb1(), 0);
    check("reset_rgb_valid", int'(bus1.rgb_valid), 0);
    check("reset_level", int'(bus1.level), 16);
    check("reset_busy", int'(bus1.fade_busy), 0);
    check("reset_done", int'(bus1.fade_done), 0);

    // Back-to-back lookups: vector k emerges two cycles after it is driven.
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        bus1.index     = vecs[k].idx;
        bus1.pix_valid = vecs[k].v;
      end else begin
        bus1.pix_valid = 1'b0;
      end
      cyc();
      if (k >= 1) begin
        check($sformatf("vec%0d_rgb", k - 1), rgb1(), int'(vecs[k-1].exp_rgb));
        check($sformatf("vec%0d_valid", k - 1), int'(bus1.rgb_valid), int'(vecs[k-1].exp_v));
      end
    end

    // Read-first write, then new value on the following lookup.
    bus1.wr_en = 1'b1; bus1.wr_addr = 4'd3; bus1.wr_data = 12'hA42;
    bus1.index = 4'd3; bus1.pix_valid = 1'b1;
    cyc();
    bus1.wr_en = 1'b0;
    cyc();
    check("write_same_cycle_old", rgb1(), 12'h333);
    cyc();
    check("write_next_cycle_new", rgb1(), 12'hA42);

    // Full fade out at one frame per step, index 15 held on the pixel path.
    bus1.index = 4'd15; bus1.pix_valid = 1'b1;
    bus1.fade_start = 1'b1; bus1.fade_dir = 1'b0;
    cyc();
    bus1.fade_start = 1'b0;
    check("fo_busy_rise", int'(bus1.fade_busy), 1);
    check("fo_level_start", int'(bus1.level), 16);
    for (int k = 1; k <= 16; k++) begin
      pulse_tick1();
      check($sformatf("fo%0d_level", k), int'(bus1.level), 16 - k);
      check($sformatf("fo%0d_done", k), int'(bus1.fade_done), (k == 16) ? 1 : 0);
      check($sformatf("fo%0d_busy", k), int'(bus1.fade_busy), (k == 16) ? 0 : 1);
      cyc();
      check($sformatf("fo%0d_red", k), int'(bus1.red), (15 * (16 - k)) >> 4);
      check($sformatf("fo%0d_done_low", k), int'(bus1.fade_done), 0);
      if (k == 8) check("fo_level8_rgb", rgb1(), 12'h777);
    end
    check("fo_black_rgb", rgb1(), 0);
    pulse_tick1();
    cyc();
    check("idle_tick_no_wrap", int'(bus1.level), 0);
    check("idle_tick_busy", int'(bus1.fade_busy), 0);

    // Start and tick in the same idle cycle: the tick is not counted.
    do_reset();
    bus1.fade_start = 1'b1; bus1.fade_dir = 1'b0; bus1.frame_tick = 1'b1;
    cyc();
    bus1.fade_start = 1'b0; bus1.frame_tick = 1'b0;
    check("start_tick_level", int'(bus1.level), 16);
    check("start_tick_busy", int'(bus1.fade_busy), 1);
    pulse_tick1();
    check("start_tick_first_step", int'(bus1.level), 15);

    // Reset mid-fade at level 9 restores level, FSM and grey palette.
    do_reset();
    bus1.wr_en = 1'b1; bus1.wr_addr = 4'd3; bus1.wr_data = 12'hA42;
    bus1.fade_start = 1'b1; bus1.fade_dir = 1'b0;
    cyc();
    bus1.wr_en = 1'b0; bus1.fade_start = 1'b0;
    for (int k = 0; k < 7; k++) pulse_tick1();
    check("abort_level_before", int'(bus1.level), 9);
    Reset_n = 1'b0;
    cyc();
    check("abort_level", int'(bus1.level), 16);
    check("abort_busy", int'(bus1.fade_busy), 0);
    check("abort_done", int'(bus1.fade_done), 0);
    check("abort_rgb_valid", int'(bus1.rgb_valid), 0);
    check("abort_rgb", rgb1(), 0);
    Reset_n = 1'b1;
    bus1.index = 4'd3; bus1.pix_valid = 1'b1;
    cyc();
    check("abort_no_done", int'(bus1.fade_done), 0);
    cyc();
    check("abort_palette_grey", rgb1(), 12'h333);

    // Fade in requested while already at full brightness.
    bus1.fade_start = 1'b1; bus1.fade_dir = 1'b1;
    cyc();
    bus1.fade_start = 1'b0;
    check("at_target_busy", int'(bus1.fade_busy), 1);
    check("at_target_done_early", int'(bus1.fade_done), 0);
    cyc();
    check("at_target_busy_drop", int'(bus1.fade_busy), 0);
    check("at_target_done", int'(bus1.fade_done), 1);
    check("at_target_level", int'(bus1.level), 16);
    cyc();
    check("at_target_done_once", int'(bus1.fade_done), 0);

    // Three frames per step: fade out, then fade in with an ignored restart.
    bus3.fade_start = 1'b1; bus3.fade_dir = 1'b0;
    cyc();
    bus3.fade_start = 1'b0;
    for (int t = 1; t <= 48; t++) begin
      pulse_tick3();
      check($sformatf("f3out%0d_level", t), int'(bus3.level), 16 - t / 3);
      check($sformatf("f3out%0d_done", t), int'(bus3.fade_done), (t == 48) ? 1 : 0);
      cyc();
    end
    check("f3out_idle", int'(bus3.fade_busy), 0);
    bus3.fade_start = 1'b1; bus3.fade_dir = 1'b1;
    cyc();
    bus3.fade_start = 1'b0;
    check("f3in_busy", int'(bus3.fade_busy), 1);
    for (int t = 1; t <= 48; t++) begin
      pulse_tick3();
      check($sformatf("f3in%0d_level", t), int'(bus3.level), t / 3);
      check($sformatf("f3in%0d_busy", t), int'(bus3.fade_busy), (t == 48) ? 0 : 1);
      check($sformatf("f3in%0d_done", t), int'(bus3.fade_done), (t == 48) ? 1 : 0);
      if (t == 10) begin
        bus3.fade_start = 1'b1; bus3.fade_dir = 1'b0;
      end
      cyc();
      bus3.fade_start = 1'b0;
    end
    check("f3in_final_level", int'(bus3.level), 16);
    check("f3in_done_once", int'(bus3.fade_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
